branch_resolve_unit: RTL

Execute-stage branch resolution and fetch-PC generation for the RV32I pipeline. Sits directly downstream of `branch_comp`: it drives `brun` into the comparator from the branch's funct3, consumes `breq`/`brlt`, and decides taken/not-taken. It owns the fetch PC register, redirects it on taken branches and jumps, and flushes wrong-path instructions for a fixed number of cycles. It also keeps saturating branch statistics counters.

---
 rtl/branch_resolve_unit.sv | 200 ++++++++++++++++++++
 1 files changed

// File: rtl/branch_resolve_unit.sv
// branch_resolve_unit
// Execute-stage branch resolution and fetch-PC generation.
// - Drives the compare mode (brun) into branch_comp and consumes breq/brlt.
// - Owns the fetch PC and redirects it on taken branches, JAL and JALR.
// - Holds flush high for FLUSH_CYCLES unstalled cycles after every redirect.
// - Keeps saturating statistics counters for conditional branches.
module branch_resolve_unit #(
  parameter int unsigned          PC_WIDTH     = 32,
  parameter logic [PC_WIDTH-1:0]  RESET_PC     = PC_WIDTH'(32'h0000_2000),
  parameter int unsigned          FLUSH_CYCLES = 2,
  parameter int unsigned          CNT_WIDTH    = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 ex_valid,
  input  logic                 ex_is_branch,
  input  logic                 ex_is_jal,
  input  logic                 ex_is_jalr,
  input  logic [2:0]           ex_funct3,
  input  logic [PC_WIDTH-1:0]  ex_target,
  input  logic                 breq,
  input  logic                 brlt,
  input  logic                 stall,
  output logic                 brun,
  output logic [PC_WIDTH-1:0]  pc,
  output logic                 pc_redirect,
  output logic                 flush,
  output logic                 misaligned,
  output logic [CNT_WIDTH-1:0] branch_count,
  output logic [CNT_WIDTH-1:0] taken_count
);

  typedef enum logic [0:0] {
    ST_RUN   = 1'b0,
    ST_FLUSH = 1'b1
  } state_t;

  localparam logic [PC_WIDTH-1:0]  PC_INC     = PC_WIDTH'(32'd4);
  localparam logic [PC_WIDTH-1:0]  JALR_MASK  = {{(PC_WIDTH-1){1'b1}}, 1'b0};
  localparam logic [2:0]           FLUSH_LOAD = 3'(FLUSH_CYCLES);
  localparam logic [CNT_WIDTH-1:0] CNT_MAX    = {CNT_WIDTH{1'b1}};
  localparam logic [CNT_WIDTH-1:0] CNT_ONE    = CNT_WIDTH'(32'd1);

  state_t                state_r, state_next_s;
  logic [2:0]            fcnt_r, fcnt_next_s;
  logic [PC_WIDTH-1:0]   pc_r, pc_next_s;
  logic                  redirect_r, redirect_next_s;
  logic                  mis_r, mis_next_s;
  logic [CNT_WIDTH-1:0]  bcnt_r, bcnt_next_s;
  logic [CNT_WIDTH-1:0]  tcnt_r, tcnt_next_s;

  logic                  resolve_s;
  logic                  cond_taken_s;
  logic                  counted_s;
  logic                  taken_s;
  logic [PC_WIDTH-1:0]   target_raw_s;
  logic                  count_branch_s;
  logic                  count_taken_s;

  // funct3[1] selects the unsigned compare for BLTU/BGEU; idle when no branch
  assign brun = ex_is_branch & ex_funct3[1];

  assign pc           = pc_r;
  assign pc_redirect  = redirect_r;
  assign misaligned   = mis_r;
  assign flush        = (state_r == ST_FLUSH);
  assign branch_count = bcnt_r;
  assign taken_count  = tcnt_r;

  // Conditional-branch outcome from funct3 and the comparator flags
  always_comb begin
    cond_taken_s = 1'b0;
    counted_s    = 1'b1;
    case (ex_funct3)
      3'b000:  cond_taken_s = breq;
      3'b001:  cond_taken_s = ~breq;
      3'b100:  cond_taken_s = brlt;
      3'b110:  cond_taken_s = brlt;
      3'b101:  cond_taken_s = ~brlt;
      3'b111:  cond_taken_s = ~brlt;
      default: begin
        // 010/011 are not branch encodings: never taken, never counted
        cond_taken_s = 1'b0;
        counted_s    = 1'b0;
      end
    endcase
  end

  // Resolve decision with jal > jalr > branch priority and target selection
  always_comb begin
    resolve_s      = ex_valid & ~stall & (state_r == ST_RUN);
    taken_s        = 1'b0;
    target_raw_s   = ex_target;
    count_branch_s = 1'b0;
    count_taken_s  = 1'b0;
    if (ex_is_jal) begin
      taken_s      = 1'b1;
      target_raw_s = ex_target;
    end else if (ex_is_jalr) begin
      taken_s      = 1'b1;
      target_raw_s = ex_target & JALR_MASK;
    end else if (ex_is_branch) begin
      taken_s        = cond_taken_s;
      target_raw_s   = ex_target;
      count_branch_s = resolve_s & counted_s;
      count_taken_s  = resolve_s & counted_s & cond_taken_s;
    end else begin
      taken_s      = 1'b0;
      target_raw_s = ex_target;
    end
  end

  // Next state, fetch PC, flush counter and one-cycle redirect pulses
  always_comb begin
    state_next_s    = state_r;
    fcnt_next_s     = fcnt_r;
    pc_next_s       = pc_r;
    redirect_next_s = 1'b0;
    mis_next_s      = 1'b0;
    case (state_r)
      ST_RUN: begin
        if (resolve_s && taken_s) begin
          // Low two bits are forced clear; bit 1 set means a misaligned target
          pc_next_s       = {target_raw_s[PC_WIDTH-1:2], 2'b00};
          fcnt_next_s     = FLUSH_LOAD;
          state_next_s    = ST_FLUSH;
          redirect_next_s = 1'b1;
          mis_next_s      = target_raw_s[1];
        end else if (!stall) begin
          pc_next_s = pc_r + PC_INC;
        end else begin
          pc_next_s = pc_r;
        end
      end
      ST_FLUSH: begin
        // Execute inputs are wrong-path here and are deliberately ignored
        if (!stall) begin
          pc_next_s = pc_r + PC_INC;
          if (fcnt_r <= 3'd1) begin
            fcnt_next_s  = 3'd0;
            state_next_s = ST_RUN;
          end else begin
            fcnt_next_s = fcnt_r - 3'd1;
          end
        end else begin
          pc_next_s = pc_r;
        end
      end
      default: begin
        state_next_s = ST_RUN;
        fcnt_next_s  = 3'd0;
      end
    endcase
  end

  // Saturating statistics: stick at all-ones instead of wrapping
  always_comb begin
    bcnt_next_s = bcnt_r;
    tcnt_next_s = tcnt_r;
    if (count_branch_s && (bcnt_r != CNT_MAX)) begin
      bcnt_next_s = bcnt_r + CNT_ONE;
    end else begin
      bcnt_next_s = bcnt_r;
    end
    if (count_taken_s && (tcnt_r != CNT_MAX)) begin
      tcnt_next_s = tcnt_r + CNT_ONE;
    end else begin
      tcnt_next_s = tcnt_r;
    end
  end

  // State, PC and pulse registers; reset aborts any flush in progress
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r    <= ST_RUN;
      fcnt_r     <= 3'd0;
      pc_r       <= RESET_PC;
      redirect_r <= 1'b0;
      mis_r      <= 1'b0;
    end else begin
      state_r    <= state_next_s;
      fcnt_r     <= fcnt_next_s;
      pc_r       <= pc_next_s;
      redirect_r <= redirect_next_s;
      mis_r      <= mis_next_s;
    end
  end

  // Statistics counter registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bcnt_r <= {CNT_WIDTH{1'b0}};
      tcnt_r <= {CNT_WIDTH{1'b0}};
    end else begin
      bcnt_r <= bcnt_next_s;
      tcnt_r <= tcnt_next_s;
    end
  end

endmodule
